// File: rtl/fwd_pkg.sv
// Shared forwarding-select codes and tag field defaults for the EX operand forwarding unit.
// Latency/backpressure: n/a (constants only).
package fwd_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_MEM  = 2'b01;
  localparam fwd_sel_t FWD_WB   = 2'b10;
  localparam fwd_sel_t FWD_ZERO = 2'b11;

  localparam int RA_W_DEF = 5;

endpackage

// File: rtl/fwd_operand_sel.sv
// One EX operand: priority force-zero > MEM > WB > RF/alt, x0 never forwarded.
// Latency: combinational. Backpressure: none.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            force_zero,
  input  logic            alt_sel,
  input  logic [RA_W-1:0] rs,
  input  logic            mem_wr,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_wr,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] alt_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wb_data,
  output fwd_sel_t        sel,
  output logic [XLEN-1:0] data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_wr && (mem_rd != '0) && (mem_rd == rs);
  assign wb_hit  = wb_wr && (wb_rd != '0) && (wb_rd == rs);

  always_comb begin
    sel  = FWD_NONE;
    data = alt_sel ? alt_data : rf_data;
    if (force_zero) begin
      sel  = FWD_ZERO;
      data = '0;
    end else if (mem_hit) begin
      sel  = FWD_MEM;
      data = mem_data;
    end else if (wb_hit) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

endmodule

// File: rtl/operand_forward_unit.sv
// EX-stage operand forwarding with EX/MEM/WB tag tracking and load-use stall detection.
// Latency: operands combinational; tags advance one slot per clk. Backpressure: none downstream; stall holds IF/ID.
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int RA_W    = RA_W_DEF,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NUM_SRC*RA_W-1:0] id_rs,
  input  logic [RA_W-1:0]         id_rd,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic [NUM_SRC-1:0]      id_force_zero,
  input  logic [NUM_SRC-1:0]      id_alt_sel,
  input  logic                    flush,
  input  logic [NUM_SRC*XLEN-1:0] ex_rf_data,
  input  logic [NUM_SRC*XLEN-1:0] ex_alt_data,
  input  logic [XLEN-1:0]         mem_alu_result,
  input  logic [XLEN-1:0]         wb_data,
  output logic [NUM_SRC*XLEN-1:0] ex_op_data,
  output logic [NUM_SRC*2-1:0]    ex_fwd_sel,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_count
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
  } dst_t;

  typedef struct packed {
    dst_t                    dst;
    logic [NUM_SRC*RA_W-1:0] rs;
    logic [NUM_SRC-1:0]      force_zero;
    logic [NUM_SRC-1:0]      alt_sel;
  } ex_tag_t;

  ex_tag_t            ex_q;
  ex_tag_t            id_tag;
  dst_t               mem_q;
  dst_t               wb_q;
  logic [NUM_SRC-1:0] rs_hit;
  logic [NUM_SRC-1:0] load_fwd;

  always_comb begin
    id_tag               = '0;
    id_tag.dst.valid     = 1'b1;
    id_tag.dst.rd        = id_rd;
    id_tag.dst.reg_write = id_reg_write;
    id_tag.dst.mem_read  = id_mem_read;
    id_tag.rs            = id_rs;
    id_tag.force_zero    = id_force_zero;
    id_tag.alt_sel       = id_alt_sel;
  end

  // Force-zero operands never read the register, so they cannot create a load-use hazard.
  always_comb begin
    rs_hit   = '0;
    load_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_hit[i]   = (id_rs[i*RA_W +: RA_W] == ex_q.dst.rd) && !id_force_zero[i];
      load_fwd[i] = ex_q.dst.valid && mem_q.valid && mem_q.mem_read && (mem_q.rd != '0) &&
                    (mem_q.rd == ex_q.rs[i*RA_W +: RA_W]) && !ex_q.force_zero[i];
    end
  end

  assign stall = id_valid && ex_q.dst.valid && ex_q.dst.mem_read &&
                 (ex_q.dst.rd != '0) && (|rs_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      ex_q  <= (stall || flush || !id_valid) ? ex_tag_t'('0) : id_tag;
      mem_q <= ex_q.dst;
      wb_q  <= mem_q;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    fwd_operand_sel #(
      .XLEN (XLEN),
      .RA_W (RA_W)
    ) u_sel (
      .force_zero (ex_q.force_zero[i]),
      .alt_sel    (ex_q.alt_sel[i]),
      .rs         (ex_q.rs[i*RA_W +: RA_W]),
      .mem_wr     (mem_q.valid && mem_q.reg_write),
      .mem_rd     (mem_q.rd),
      .wb_wr      (wb_q.valid && wb_q.reg_write),
      .wb_rd      (wb_q.rd),
      .rf_data    (ex_rf_data[i*XLEN +: XLEN]),
      .alt_data   (ex_alt_data[i*XLEN +: XLEN]),
      .mem_data   (mem_alu_result),
      .wb_data    (wb_data),
      .sel        (ex_fwd_sel[i*2 +: 2]),
      .data       (ex_op_data[i*XLEN +: XLEN])
    );
  end

  a_no_load_fwd: assert property (@(posedge clk) disable iff (rst) load_fwd == '0);

endmodule

// File: tb/tb_operand_forward_unit.sv
// Randomized and directed bench for operand_forward_unit against an instruction-history model.
module tb_operand_forward_unit;

  localparam int XLEN    = 32;
  localparam int NS      = 2;
  localparam int RA_W    = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 id_valid;
  logic [NS*RA_W-1:0]   id_rs;
  logic [RA_W-1:0]      id_rd;
  logic                 id_reg_write;
  logic                 id_mem_read;
  logic [NS-1:0]        id_force_zero;
  logic [NS-1:0]        id_alt_sel;
  logic                 flush;
  logic [NS*XLEN-1:0]   ex_rf_data;
  logic [NS*XLEN-1:0]   ex_alt_data;
  logic [XLEN-1:0]      mem_alu_result;
  logic [XLEN-1:0]      wb_data;
  logic [NS*XLEN-1:0]   ex_op_data;
  logic [NS*2-1:0]      ex_fwd_sel;
  logic                 stall;
  logic [CNT_W-1:0]     stall_count;

  always #5 clk = ~clk;

  operand_forward_unit #(
    .XLEN    (XLEN),
    .NUM_SRC (NS),
    .RA_W    (RA_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_force_zero  (id_force_zero),
    .id_alt_sel     (id_alt_sel),
    .flush          (flush),
    .ex_rf_data     (ex_rf_data),
    .ex_alt_data    (ex_alt_data),
    .mem_alu_result (mem_alu_result),
    .wb_data        (wb_data),
    .ex_op_data     (ex_op_data),
    .ex_fwd_sel     (ex_fwd_sel),
    .stall          (stall),
    .stall_count    (stall_count)
  );

  // Instruction as seen by the model; hist holds {WB, MEM, EX}, oldest first.
  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit mr;
    int rs[NS];
    bit fz[NS];
    bit alt[NS];
  } ins_t;

  ins_t hist[$];
  int   exp_cnt;
  int   n_chk;
  int   n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t bubble();
    ins_t b;
    b.valid = 0; b.rd = 0; b.rw = 0; b.mr = 0;
    for (int i = 0; i < NS; i++) begin
      b.rs[i] = 0; b.fz[i] = 0; b.alt[i] = 0;
    end
    return b;
  endfunction

  function automatic ins_t from_id();
    ins_t n;
    n.valid = 1; n.rd = int'(id_rd); n.rw = id_reg_write; n.mr = id_mem_read;
    for (int i = 0; i < NS; i++) begin
      n.rs[i]  = int'(id_rs[i*RA_W +: RA_W]);
      n.fz[i]  = id_force_zero[i];
      n.alt[i] = id_alt_sel[i];
    end
    return n;
  endfunction

  function automatic bit model_stall();
    ins_t ex = hist[2];
    if (!(id_valid && ex.valid && ex.mr && ex.rd != 0)) return 0;
    for (int i = 0; i < NS; i++)
      if (int'(id_rs[i*RA_W +: RA_W]) == ex.rd && !id_force_zero[i]) return 1;
    return 0;
  endfunction

  // Youngest older writer of the operand's register supplies the value.
  function automatic void exp_op(input int i, output logic [1:0] sel, output logic [XLEN-1:0] val);
    ins_t ex = hist[2];
    ins_t prod[2];
    logic [XLEN-1:0] res[2];
    prod[0] = hist[1]; res[0] = mem_alu_result;
    prod[1] = hist[0]; res[1] = wb_data;
    if (ex.fz[i]) begin
      sel = 2'b11; val = '0;
      return;
    end
    sel = 2'b00;
    val = ex.alt[i] ? ex_alt_data[i*XLEN +: XLEN] : ex_rf_data[i*XLEN +: XLEN];
    for (int k = 0; k < 2; k++) begin
      if (prod[k].valid && prod[k].rw && prod[k].rd != 0 && prod[k].rd == ex.rs[i]) begin
        sel = 2'(k + 1); val = res[k];
        return;
      end
    end
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(bubble());
    exp_cnt = 0;
  endtask

  task automatic cycle();
    logic [1:0]      s;
    logic [XLEN-1:0] v;
    bit              st;
    #1;
    st = model_stall();
    check("stall", stall, st);
    check("stall_count", stall_count, exp_cnt);
    for (int i = 0; i < NS; i++) begin
      exp_op(i, s, v);
      check($sformatf("sel%0d", i), ex_fwd_sel[i*2 +: 2], s);
      check($sformatf("op%0d", i), ex_op_data[i*XLEN +: XLEN], v);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (st && exp_cnt < CNT_MAX) exp_cnt++;
      if (st || flush || !id_valid) hist.push_back(bubble());
      else hist.push_back(from_id());
      void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rs0, input int rs1, input int rd,
                        input bit rw, input bit mr, input logic [1:0] fz, input logic [1:0] alt);
    id_valid           = v;
    id_rs[0 +: RA_W]   = rs0[RA_W-1:0];
    id_rs[RA_W +: RA_W] = rs1[RA_W-1:0];
    id_rd              = rd[RA_W-1:0];
    id_reg_write       = rw;
    id_mem_read        = mr;
    id_force_zero      = fz;
    id_alt_sel         = alt;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    ex_rf_data = '0; ex_alt_data = '0; mem_alu_result = '0; wb_data = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // MEM-stage forward
    set_id(1, 0, 0, 5, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 5, 0, 9, 1, 0, 2'b00, 2'b00); cycle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    ex_rf_data[31:0] = 32'd7; mem_alu_result = 32'h11;
    #1;
    check("t1_sel0", ex_fwd_sel[1:0], 2'b01);
    check("t1_op0", ex_op_data[31:0], 32'h11);
    check("t1_stall", stall, 1'b0);
    cycle();

    // MEM wins over WB; then WB alone
    set_id(1, 0, 0, 5, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 0, 0, 5, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 0, 5, 10, 1, 0, 2'b00, 2'b00); cycle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    mem_alu_result = 32'h22; wb_data = 32'h33;
    #1;
    check("t2_sel1_mem", ex_fwd_sel[3:2], 2'b01);
    check("t2_op1_mem", ex_op_data[63:32], 32'h22);
    cycle();
    set_id(1, 0, 0, 5, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 0, 0, 5, 0, 0, 2'b00, 2'b00); cycle();
    set_id(1, 0, 5, 10, 1, 0, 2'b00, 2'b00); cycle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    #1;
    check("t2_sel1_wb", ex_fwd_sel[3:2], 2'b10);
    check("t2_op1_wb", ex_op_data[63:32], 32'h33);
    cycle();

    // Load-use stall
    set_id(1, 0, 0, 6, 1, 1, 2'b00, 2'b00); cycle();
    set_id(1, 6, 0, 11, 1, 0, 2'b00, 2'b00);
    #1;
    check("t3_stall", stall, 1'b1);
    check("t3_cnt0", stall_count, 0);
    cycle();
    #1;
    check("t3_stall_once", stall, 1'b0);
    check("t3_cnt1", stall_count, 1);
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    wb_data = 32'h44;
    #1;
    check("t3_sel0_wb", ex_fwd_sel[1:0], 2'b10);
    check("t3_op0_wb", ex_op_data[31:0], 32'h44);
    cycle();

    // x0 never forwarded; force-zero
    set_id(1, 0, 0, 0, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 0, 0, 12, 1, 0, 2'b00, 2'b00); cycle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    mem_alu_result = 32'hFF; ex_rf_data[31:0] = 32'hAB;
    #1;
    check("t4_sel0_x0", ex_fwd_sel[1:0], 2'b00);
    check("t4_op0_x0", ex_op_data[31:0], 32'hAB);
    cycle();
    set_id(1, 0, 0, 0, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 0, 0, 12, 1, 0, 2'b01, 2'b00); cycle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    #1;
    check("t4_sel0_fz", ex_fwd_sel[1:0], 2'b11);
    check("t4_op0_fz", ex_op_data[31:0], 32'h0);
    cycle();

    // Flush together with stall
    set_id(1, 0, 0, 6, 1, 1, 2'b00, 2'b00); cycle();
    set_id(1, 6, 0, 13, 1, 0, 2'b00, 2'b00); flush = 1'b1;
    #1;
    check("t5_stall", stall, 1'b1);
    cycle();
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    #1;
    check("t5_cnt", stall_count, 2);
    check("t5_sel0_bubble", ex_fwd_sel[1:0], 2'b00);
    cycle();

    // Reset with live tags, then saturation
    set_id(1, 0, 0, 5, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 0, 0, 7, 1, 0, 2'b00, 2'b00); cycle();
    set_id(1, 5, 7, 14, 1, 0, 2'b00, 2'b00); rst = 1'b1; cycle();
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    #1;
    check("t6_sel", ex_fwd_sel, '0);
    check("t6_stall", stall, 1'b0);
    check("t6_cnt", stall_count, 0);
    cycle();
    repeat (20) begin
      set_id(1, 0, 0, 6, 1, 1, 2'b00, 2'b00); cycle();
      set_id(1, 6, 0, 15, 1, 0, 2'b00, 2'b00); cycle();
    end
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    #1;
    check("t6_cnt_sat", stall_count, CNT_MAX);
    cycle();

    // Random traffic on a small register set to make hazards frequent
    repeat (3000) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
             {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0}, 2'($urandom_range(0, 3)));
      flush          = ($urandom_range(0, 7) == 0);
      rst            = ($urandom_range(0, 99) == 0);
      ex_rf_data     = {$urandom, $urandom};
      ex_alt_data    = {$urandom, $urandom};
      mem_alu_result = $urandom;
      wb_data        = $urandom;
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
